// File: rtl/imu_seq_pkg.sv
// Shared state type, command tables and read-list sizing for the IMU sequencer.
// Defining IMU_ACCEL_EN extends the read list with the accel X byte pair.
package imu_seq_pkg;

  typedef enum logic [2:0] {
    INIT_DLY,
    CFG_WRT,
    CFG_WAIT,
    WAIT_INT,
    RD_WRT,
    RD_WAIT,
    PUBLISH
  } state_t;

  localparam int NUM_CFG = 4;
`ifdef IMU_ACCEL_EN
  localparam int NUM_RD = 4;
`else
  localparam int NUM_RD = 2;
`endif
  localparam int RD_IW = $clog2(NUM_RD);

  localparam logic [1:0] CFG_LAST = 2'(NUM_CFG - 1);
  localparam logic [1:0] RD_LAST  = 2'(NUM_RD - 1);

  // INT on data ready, accel config, gyro config, rounding
  localparam logic [15:0] CFG_CMD [NUM_CFG] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
`ifdef IMU_ACCEL_EN
  localparam logic [15:0] RD_CMD [NUM_RD] = '{16'hA600, 16'hA700, 16'hA800, 16'hA900};
`else
  localparam logic [15:0] RD_CMD [NUM_RD] = '{16'hA600, 16'hA700};
`endif

endpackage

// File: rtl/imu_int_sync.sv
// Two-flop synchronizer for the IMU data-ready line; output lags the pin by two cycles, resets low.
module imu_int_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_int,
  output logic o_int_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_int;
      r_sync <= r_meta;
    end
  end

  assign o_int_sync = r_sync;

endmodule

// File: rtl/imu_seq.sv
// IMU sequencer: power-up delay, config writes, then INT-driven reads assembled into yaw_rt with a 1-cycle vld.
// First read starts 3 cycles after INT rises; each SPI transaction stalls until spi_done. IMU_ACCEL_EN adds accel X.
module imu_seq
  import imu_seq_pkg::*;
#(
  parameter int PWRUP_BITS = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_int,
  input  logic        i_spi_done,
  input  logic [15:0] i_spi_rd_data,
  output logic        o_spi_wrt,
  output logic [15:0] o_spi_cmd,
  output logic        o_cfg_done,
  output logic [15:0] o_yaw_rt,
  output logic [15:0] o_ax,
  output logic        o_vld
);

  state_t                r_state, w_state_nxt;
  logic [PWRUP_BITS-1:0] r_cnt, w_cnt_inc;
  logic [1:0]            r_idx, w_idx_nxt;
  logic [15:0]           r_spi_cmd, r_yaw_rt;
  logic                  r_cfg_done;
  logic [7:0]            r_hold [NUM_RD];
  logic [7:0]            w_byte [NUM_RD];
  logic                  w_int_sync, w_spi_wrt, w_vld, w_cfg_set, w_cap, w_pub;
  logic                  w_unused_rd;

  imu_int_sync u_int_sync (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_int      (i_int),
    .o_int_sync (w_int_sync)
  );

  assign w_cnt_inc   = r_cnt + PWRUP_BITS'(1);
  assign w_pub       = w_cap && (r_idx == RD_LAST);
  assign w_unused_rd = ^i_spi_rd_data[15:8];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= INIT_DLY;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_spi_wrt   = 1'b0;
    w_vld       = 1'b0;
    w_cfg_set   = 1'b0;
    w_cap       = 1'b0;
    case (r_state)
      INIT_DLY: if (&w_cnt_inc) begin
        w_state_nxt = CFG_WRT;
        w_idx_nxt   = '0;
      end
      CFG_WRT: begin
        w_spi_wrt   = 1'b1;
        w_state_nxt = CFG_WAIT;
      end
      CFG_WAIT: if (i_spi_done) begin
        if (r_idx == CFG_LAST) begin
          w_cfg_set   = 1'b1;
          w_state_nxt = WAIT_INT;
        end else begin
          w_idx_nxt   = r_idx + 2'd1;
          w_state_nxt = CFG_WRT;
        end
      end
      WAIT_INT: if (w_int_sync) begin
        w_idx_nxt   = '0;
        w_state_nxt = RD_WRT;
      end
      RD_WRT: begin
        w_spi_wrt   = 1'b1;
        w_state_nxt = RD_WAIT;
      end
      RD_WAIT: if (i_spi_done) begin
        w_cap = 1'b1;
        if (r_idx == RD_LAST) begin
          w_state_nxt = PUBLISH;
        end else begin
          w_idx_nxt   = r_idx + 2'd1;
          w_state_nxt = RD_WRT;
        end
      end
      PUBLISH: begin
        w_vld       = 1'b1;
        w_state_nxt = WAIT_INT;
      end
      default: w_state_nxt = INIT_DLY;
    endcase
  end

  // The last byte arrives on the publish edge, so it bypasses its holding register.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) w_byte[i] = r_hold[i];
    w_byte[r_idx[RD_IW-1:0]] = i_spi_rd_data[7:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_spi_cmd  <= '0;
      r_cfg_done <= 1'b0;
      r_yaw_rt   <= '0;
      for (int i = 0; i < NUM_RD; i++) r_hold[i] <= '0;
    end else begin
      r_idx <= w_idx_nxt;
      if (r_state == INIT_DLY) r_cnt <= w_cnt_inc;
      if (w_cfg_set) r_cfg_done <= 1'b1;
      if (w_state_nxt == CFG_WRT)     r_spi_cmd <= CFG_CMD[w_idx_nxt];
      else if (w_state_nxt == RD_WRT) r_spi_cmd <= RD_CMD[w_idx_nxt[RD_IW-1:0]];
      if (w_cap) r_hold[r_idx[RD_IW-1:0]] <= i_spi_rd_data[7:0];
      if (w_pub) r_yaw_rt <= {w_byte[1], w_byte[0]};
    end
  end

`ifdef IMU_ACCEL_EN
  logic [15:0] r_ax;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_ax <= '0;
    else if (w_pub) r_ax <= {w_byte[3], w_byte[2]};
  end

  assign o_ax = r_ax;
`else
  assign o_ax = '0;
`endif

  assign o_spi_wrt  = w_spi_wrt;
  assign o_spi_cmd  = r_spi_cmd;
  assign o_cfg_done = r_cfg_done;
  assign o_yaw_rt   = r_yaw_rt;
  assign o_vld      = w_vld;

endmodule

// File: doc/imu_seq.md
# imu_seq

Sequencer that owns the SPI monarch on behalf of the inertial sensor. After a power-up delay it issues a fixed list of configuration writes to the IMU. It then waits for the sensor's data-ready interrupt and issues the register reads that assemble a 16-bit yaw-rate sample. Each completed sample is published with a one-cycle valid strobe. It sits between the SPI monarch (which it drives through `spi_wrt`/`spi_cmd`) and the heading/integration logic that consumes `yaw_rt`.

## Interface
- `PWRUP_BITS`, 16, width of power-up delay counter; the delay ends when the counter reaches all ones.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `INT`  in  1  sensor data-ready; asynchronous, active high.
- `spi_done`  in  1  SPI monarch done level; low from the cycle after `spi_wrt`, high once the transaction completes.
- `spi_rd_data`  in  16  SPI monarch read data; only `[7:0]` is meaningful.
- `spi_wrt`  out  1  single-cycle transaction start.
- `spi_cmd`  out  16  command word for the SPI monarch.
- `cfg_done`  out  1  high once all configuration writes have completed; sticky until reset.
- `yaw_rt`  out  16  last published yaw rate, `{high byte, low byte}`.
- `ax`  out  16  last published accel X (see Configuration).
- `vld`  out  1  one-cycle strobe; new sample present on the outputs.

## Operation
- States: `INIT_DLY`, `CFG_WRT`, `CFG_WAIT`, `WAIT_INT`, `RD_WRT`, `RD_WAIT`, `PUBLISH`.
- `INIT_DLY`:
  - Power-up counter increments every cycle.
  - When the counter reaches all ones, go to `CFG_WRT` with `idx` = 0.
- `CFG_WRT`:
  - `spi_wrt` = 1 for this cycle.
  - `spi_cmd` = `CFG_CMD[idx]`.
  - Go to `CFG_WAIT`.
- `CFG_WAIT`:
  - `spi_cmd` is held.
  - On `spi_done` = 1: if `idx` = `NUM_CFG`-1, set `cfg_done` and go to `WAIT_INT`; otherwise `idx`++ and go to `CFG_WRT`.
- Configuration commands, in order: 0x0D02 (INT on data ready), 0x1053 (accel config), 0x1150 (gyro config), 0x1460 (rounding).
- `WAIT_INT`: when the synchronized `INT` is 1, set `idx` = 0 and go to `RD_WRT`. `INT` is level-sensitive, because the sensor clears it when the data is read.
- `RD_WRT` / `RD_WAIT`:
  - Same handshake as the configuration states, using `RD_CMD[idx]`.
  - On `spi_done`, capture `spi_rd_data[7:0]` into holding byte `idx`.
- Read commands, in order: 0xA600 (yaw low), 0xA700 (yaw high), and with the Configuration option 0xA800 (accel X low), 0xA900 (accel X high).
- After the last read, go to `PUBLISH`:
  - `yaw_rt` (and `ax`) load from the holding bytes on the edge entering `PUBLISH`.
  - `vld` = 1 for that one cycle.
  - Go to `WAIT_INT`.
- `spi_cmd` is constant from the `spi_wrt` cycle until `spi_done` is observed.
- Reset values:
  - State is `INIT_DLY`; counter and `idx` are 0.
  - `spi_wrt`, `cfg_done`, `vld` are 0.
  - `spi_cmd`, `yaw_rt`, `ax` are 0x0000.
- Reset mid-transaction aborts immediately; the sequence restarts from the power-up delay. No SPI state is assumed afterwards.
- `INT` asserted before `cfg_done` is ignored.
- `INT` held high continuously produces back-to-back sample sets.

## Timing
- `INT` passes through two flops; a new read starts at the earliest 3 cycles after `INT` rises.
- `spi_done` seen high at cycle N in a `*_WAIT` state gives the next `spi_wrt` at N+1; there is exactly one idle cycle between transactions.
- A `*_WAIT` state is entered one cycle after `spi_wrt`. `spi_done` is already low there, so a stale done from the previous transaction is never mistaken for completion.
- Final-read `spi_done` at cycle N gives `vld` high during N+1 and `WAIT_INT` at N+2.
- `vld` is never high on two consecutive cycles.
- Power-up delay is 2^`PWRUP_BITS`-1 cycles in `INIT_DLY`; the first `spi_wrt` comes on the next cycle.

## Configuration
- `IMU_ACCEL_EN` defined:
  - Read list has 4 entries (yaw L/H, accel X L/H).
  - `ax` is updated in `PUBLISH` together with `yaw_rt`.
- `IMU_ACCEL_EN` undefined:
  - Read list has 2 entries; `ax` stays 0x0000.
  - The accel holding bytes are not built.

## Structure
- Package `imu_seq_pkg`:
  - state enum;
  - `CFG_CMD` and `RD_CMD` constant arrays;
  - `NUM_CFG`, and `NUM_RD` (selected by `IMU_ACCEL_EN`).
- Sub-module `imu_int_sync`: two-flop synchronizer for `INT`, async active-low reset to 0.
- The index counter and holding bytes live in `imu_seq`.

## Test plan
- Power-up and config, `PWRUP_BITS`=4, SPI model returns done 20 cycles after `wrt`:
  - exactly four `spi_wrt` pulses with 0x0D02, 0x1053, 0x1150, 0x1460;
  - first pulse at cycle 15;
  - `cfg_done` rises on the cycle after the fourth done.
- Sample read, `INT` raised after `cfg_done`, model returns 0x34 then 0x12:
  - `spi_cmd` is 0xA600 then 0xA700;
  - `yaw_rt` = 0x1234 with a single-cycle `vld`.
- Early `INT`, asserted during `INIT_DLY`:
  - no read command is issued before `cfg_done`;
  - the first read starts 1 cycle after `cfg_done` (the synchronized `INT` is already high).
- Handshake spacing: every `spi_wrt` comes exactly 1 cycle after the previous `spi_done` rise; `spi_cmd` is stable across each transaction.
- Reset mid-read:
  - assert `rst_n` low while in `RD_WAIT`;
  - all outputs return to reset values immediately;
  - after release the full config sequence repeats.
- With `IMU_ACCEL_EN`, model returns 0x34, 0x12, 0xCD, 0xAB: `yaw_rt` = 0x1234, `ax` = 0xABCD, one `vld` after the 4th done.
